// File: rtl/mc_mips_core.sv
// Multi-cycle MIPS core: datapath plus control FSM behind a req/ready memory port.
// Optional MC_MIPS_BNE_EN adds the bne instruction (opcode 0x05); without it 0x05 halts.
module mc_mips_core #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              halt,
  output logic [31:0]       dbg_pc,
  output logic [3:0]        dbg_state
);

  // Memory handshake: an access is held (mem_adr, mem_we, mem_wdata stable) from the
  // first cycle mem_req=1 until the cycle mem_ready=1, and completes on that edge.
  // mem_ready is ignored while mem_req=0.

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_REXEC, S_RWB, S_IEXEC, S_IWB, S_MADR, S_MRD,
    S_LWB, S_MWR, S_BEQ, S_JMP, S_JAL, S_HALT, S_BNE
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, ir, ir_n, mdr, mdr_n, a, b, alu_out, alu_n;
  logic [31:0] regs [0:31];
  logic        started;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        req, we;
  logic [31:0] adr32;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, jtarget;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign jtarget  = {pc[31:28], ir[25:0], 2'b00};

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    mdr_n   = mdr;
    alu_n   = alu_out;
    rf_we   = 1'b0;
    rf_wa   = 5'd0;
    rf_wd   = 32'd0;
    req     = 1'b0;
    we      = 1'b0;
    adr32   = pc;
    case (state)
      // started holds off the first fetch until the edge after reset release
      S_FETCH: begin
        req = started;
        if (started && mem_ready) begin
          ir_n    = mem_rdata;
          pc_n    = pc + 32'd4;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_n = pc + {imm_sext[29:0], 2'b00};
        case (opcode)
          6'h00:        state_n = S_REXEC;
          6'h23, 6'h2B: state_n = S_MADR;
          6'h04:        state_n = S_BEQ;
`ifdef MC_MIPS_BNE_EN
          6'h05:        state_n = S_BNE;
`endif
          6'h02:        state_n = S_JMP;
          6'h03:        state_n = S_JAL;
          6'h08:        state_n = S_IEXEC;
          default:      state_n = S_HALT;
        endcase
      end
      S_REXEC: begin
        state_n = S_RWB;
        case (funct)
          6'h20:   alu_n = a + b;
          6'h22:   alu_n = a - b;
          6'h24:   alu_n = a & b;
          6'h25:   alu_n = a | b;
          6'h2A:   alu_n = {31'd0, $signed(a) < $signed(b)};
          default: state_n = S_HALT;
        endcase
      end
      S_RWB: begin
        rf_we = 1'b1; rf_wa = rd; rf_wd = alu_out;
        state_n = S_FETCH;
      end
      S_IEXEC: begin
        alu_n   = a + imm_sext;
        state_n = S_IWB;
      end
      S_IWB: begin
        rf_we = 1'b1; rf_wa = rt; rf_wd = alu_out;
        state_n = S_FETCH;
      end
      S_MADR: begin
        alu_n   = a + imm_sext;
        state_n = (opcode == 6'h2B) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        req   = 1'b1;
        adr32 = alu_out;
        if (mem_ready) begin
          mdr_n   = mem_rdata;
          state_n = S_LWB;
        end
      end
      S_LWB: begin
        rf_we = 1'b1; rf_wa = rt; rf_wd = mdr;
        state_n = S_FETCH;
      end
      S_MWR: begin
        req   = 1'b1;
        we    = 1'b1;
        adr32 = alu_out;
        if (mem_ready) state_n = S_FETCH;
      end
      S_BEQ: begin
        if (a == b) pc_n = alu_out;
        state_n = S_FETCH;
      end
`ifdef MC_MIPS_BNE_EN
      S_BNE: begin
        if (a != b) pc_n = alu_out;
        state_n = S_FETCH;
      end
`endif
      S_JMP: begin
        pc_n    = jtarget;
        state_n = S_FETCH;
      end
      S_JAL: begin
        rf_we = 1'b1; rf_wa = 5'd31; rf_wd = pc;
        pc_n    = jtarget;
        state_n = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      started <= 1'b0;
      pc      <= RESET_PC;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
    end else begin
      state   <= state_n;
      started <= 1'b1;
      pc      <= pc_n;
      ir      <= ir_n;
      mdr     <= mdr_n;
      a       <= regs[rs];
      b       <= regs[rt];
      alu_out <= alu_n;
    end
  end

  // $0 is never written, so reading regs[0] always yields zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (rf_we && rf_wa != 5'd0) begin
      regs[rf_wa] <= rf_wd;
    end
  end

  assign mem_req   = req;
  assign mem_we    = we;
  assign mem_adr   = adr32[ADDR_W-1:0];
  assign mem_wdata = b;
  assign halt      = (state == S_HALT);
  assign dbg_pc    = pc;
  assign dbg_state = state;

endmodule

// File: tb/tb_mc_mips_core.sv
// Bench for mc_mips_core: directed program, wait-state memory model, store scoreboard.
// Honours MC_MIPS_BNE_EN for the bne portion of the program.
module tb_mc_mips_core;

  localparam logic [31:0] RST_PC = 32'h0000_0400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_adr, mem_wdata, mem_rdata, dbg_pc;
  logic        mem_req, mem_we, halt;
  logic        mem_ready = 1'b0;
  logic [3:0]  dbg_state;

  mc_mips_core #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .halt      (halt),
    .dbg_pc    (dbg_pc),
    .dbg_state (dbg_state)
  );

  logic [31:0] mem [0:511];
  assign mem_rdata = mem[mem_adr[10:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic ok,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // ---------------- driver helpers ----------------
  function automatic logic [31:0] r_op(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction
  task automatic put(input logic [31:0] adr, input logic [31:0] w);
    mem[adr[10:2]] = w;
  endtask

  // ---------------- memory model + scoreboard monitor ----------------
  logic [63:0] exp_q[$];
  logic [63:0] e;
  bit          busy = 1'b0, phase2 = 1'b0, first_after_rst = 1'b0;
  int          wcnt = 0;
  logic [31:0] s_adr, s_wd;
  logic        s_we;
  int          fstart [0:511];

  function automatic int waits_for(input logic [31:0] a);
    if (phase2) return (a == RST_PC) ? 3 : 0;
    return (a == 32'h414 || a == 32'h418 || a == 32'h8) ? 3 : 0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      busy = 1'b0; wcnt = 0; mem_ready = 1'b0;
    end else if (mem_req) begin
      if (!busy) begin
        busy = 1'b1; wcnt = 0;
        s_adr = mem_adr; s_we = mem_we; s_wd = mem_wdata;
        if (!mem_we && mem_adr >= 32'h100) fstart[mem_adr[10:2]] = cyc;
        if (first_after_rst) begin
          check("first_fetch_adr", mem_adr == RST_PC, mem_adr, RST_PC);
          first_after_rst = 1'b0;
        end
      end else begin
        check("hold_adr",   mem_adr == s_adr,     mem_adr, s_adr);
        check("hold_we",    mem_we == s_we,       {31'd0, mem_we}, {31'd0, s_we});
        check("hold_wdata", mem_wdata == s_wd,    mem_wdata, s_wd);
      end
      if (wcnt >= waits_for(s_adr)) begin
        mem_ready = 1'b1;
        busy = 1'b0;
        if (mem_we) begin
          mem[mem_adr[10:2]] = mem_wdata;
          check("write_expected", exp_q.size() != 0, mem_adr, 32'd0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_adr",  mem_adr == e[63:32],  mem_adr,   e[63:32]);
            check("wr_data", mem_wdata == e[31:0], mem_wdata, e[31:0]);
          end
        end
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
    end
  end

  task automatic lat(input logic [31:0] from_a, to_a, input int exp_c);
    int d;
    d = fstart[to_a[10:2]] - fstart[from_a[10:2]];
    check($sformatf("latency_%0h", from_a), d == exp_c, d, exp_c);
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (!halt && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("halt_reached", halt == 1'b1, {31'd0, halt}, 32'd1);
  endtask

  task automatic quiet_after_halt(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mem_req || !halt) bad++;
    end
    check("halted_no_req", bad == 0, bad, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = 32'd0;
      fstart[i] = -1000;
    end
    put(32'h400, i_op(6'h08, 5'd0, 5'd1, 16'd5));         // addi $1,$0,5
    put(32'h404, i_op(6'h08, 5'd0, 5'd2, 16'd7));         // addi $2,$0,7
    put(32'h408, r_op(5'd1, 5'd2, 5'd3, 6'h20));          // add  $3,$1,$2
    put(32'h40C, r_op(5'd1, 5'd2, 5'd4, 6'h22));          // sub  $4,$1,$2
    put(32'h410, r_op(5'd1, 5'd2, 5'd5, 6'h2A));          // slt  $5,$1,$2
    put(32'h414, i_op(6'h2B, 5'd0, 5'd3, 16'h0008));      // sw   $3,8($0)
    put(32'h418, i_op(6'h23, 5'd0, 5'd6, 16'h0008));      // lw   $6,8($0)
    put(32'h41C, i_op(6'h2B, 5'd0, 5'd4, 16'h0010));
    put(32'h420, i_op(6'h2B, 5'd0, 5'd5, 16'h0014));
    put(32'h424, i_op(6'h2B, 5'd0, 5'd6, 16'h0018));
    put(32'h428, i_op(6'h08, 5'd0, 5'd0, 16'd9));         // addi $0,$0,9
    put(32'h42C, r_op(5'd0, 5'd0, 5'd7, 6'h20));          // add  $7,$0,$0
    put(32'h430, i_op(6'h2B, 5'd0, 5'd7, 16'h001C));
    put(32'h434, i_op(6'h04, 5'd1, 5'd1, 16'd2));         // beq  $1,$1,+2 -> 0x440
    put(32'h438, 32'hFC00_0000);
    put(32'h43C, 32'hFC00_0000);
    put(32'h440, j_op(6'h02, 26'h40));                    // j -> 0x100
    put(32'h100, j_op(6'h02, 26'h80));                    // j -> 0x200
    put(32'h200, j_op(6'h03, 26'hC0));                    // jal -> 0x300, $31=0x204
    put(32'h300, i_op(6'h2B, 5'd0, 5'd31, 16'h0020));
    put(32'h304, i_op(6'h04, 5'd1, 5'd2, 16'd5));         // beq not taken
    put(32'h308, i_op(6'h05, 5'd1, 5'd2, 16'd1));         // bne $1,$2,+1 -> 0x310
    put(32'h30C, 32'hFC00_0000);
    put(32'h310, i_op(6'h2B, 5'd0, 5'd1, 16'h0024));
    put(32'h314, r_op(5'd0, 5'd0, 5'd0, 6'h3F));          // illegal funct

    exp_q.push_back({32'h0000_0008, 32'd12});
    exp_q.push_back({32'h0000_0010, 32'hFFFF_FFFE});
    exp_q.push_back({32'h0000_0014, 32'd1});
    exp_q.push_back({32'h0000_0018, 32'd12});
    exp_q.push_back({32'h0000_001C, 32'd0});
    exp_q.push_back({32'h0000_0020, 32'h0000_0204});
`ifdef MC_MIPS_BNE_EN
    exp_q.push_back({32'h0000_0024, 32'd5});
`endif

    // reset state
    repeat (2) @(negedge clk);
    check("rst_req",   mem_req == 1'b0, {31'd0, mem_req}, 32'd0);
    check("rst_we",    mem_we == 1'b0,  {31'd0, mem_we},  32'd0);
    check("rst_halt",  halt == 1'b0,    {31'd0, halt},    32'd0);
    check("rst_pc",    dbg_pc == RST_PC, dbg_pc, RST_PC);
    check("rst_state", dbg_state == 4'd0, {28'd0, dbg_state}, 32'd0);
    first_after_rst = 1'b1;
    #2 rst = 1'b1;

    wait_halt(800);
    quiet_after_halt(20);
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    check("halt_state", dbg_state == 4'd13, {28'd0, dbg_state}, 32'd13);
`ifdef MC_MIPS_BNE_EN
    check("halt_pc", dbg_pc == 32'h318, dbg_pc, 32'h318);
    lat(32'h308, 32'h310, 3);
`else
    check("halt_pc", dbg_pc == 32'h30C, dbg_pc, 32'h30C);
`endif
    lat(32'h400, 32'h404, 4);
    lat(32'h408, 32'h40C, 4);
    lat(32'h414, 32'h418, 10);
    lat(32'h418, 32'h41C, 11);
    lat(32'h434, 32'h440, 3);
    lat(32'h440, 32'h100, 3);
    lat(32'h100, 32'h200, 3);
    lat(32'h200, 32'h300, 3);
    lat(32'h304, 32'h308, 3);

    // reset in the middle of a stalled fetch, then an illegal opcode
    @(negedge clk);
    rst = 1'b0;
    phase2 = 1'b1;
    put(RST_PC, 32'hFC00_0000);
    @(negedge clk);
    check("rst_clears_halt", halt == 1'b0, {31'd0, halt}, 32'd0);
    first_after_rst = 1'b1;
    #2 rst = 1'b1;
    begin
      int k = 0;
      while (!mem_req && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    @(posedge clk);
    #2;
    check("req_before_reset", mem_req == 1'b1, {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("reset_drops_req", mem_req == 1'b0, {31'd0, mem_req}, 32'd0);
    check("reset_drops_we",  mem_we == 1'b0,  {31'd0, mem_we},  32'd0);
    @(negedge clk);
    first_after_rst = 1'b1;
    #2 rst = 1'b1;
    wait_halt(40);
    quiet_after_halt(20);
    check("first_fetch_seen", first_after_rst == 1'b0, {31'd0, first_after_rst}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_mips_core.md
Name: mc_mips_core

Overview:
- Parametrised next-generation multi-cycle MIPS core: datapath plus integrated control FSM in one block.
- Replaces the fixed, single-cycle-memory datapath with a ready-handshake memory port that tolerates wait states.
- Adds a configurable reset vector and address width, sticky halt on illegal instructions, and a debug PC output.
- Sits between the top-level memory model and the testbench.

Parameters:
- ADDR_W, 32: width of mem_adr; the low ADDR_W bits of the internal 32-bit byte address are driven out.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low; 0 resets the core.
- mem_adr  out  ADDR_W  memory byte address.
- mem_wdata  out  32  store data, which is register B.
- mem_rdata  in  32  load/fetch data; valid when mem_ready=1.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; qualified by mem_req.
- mem_ready  in  1  memory completes the access in the cycle where mem_req=1 and mem_ready=1.
- halt  out  1  sticky; core has stopped on an illegal instruction.
- dbg_pc  out  32  current PC.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=RESET_PC; IR, MDR, A, B, ALUOut = 0.
  - All 32 registers = 0; FSM = FETCH.
  - mem_req=0, mem_we=0, halt=0, all immediately.
  - A transaction in flight is abandoned. After rst rises, the first FETCH starts on the next edge.
- Handshake:
  - While mem_req=1, mem_adr, mem_we and mem_wdata stay stable until mem_ready=1.
  - mem_ready outside mem_req is ignored.
  - Zero-wait: ready in the same cycle as req completes the access in that cycle.
- Register file:
  - 32x32; $0 reads 0 and writes to it are ignored.
  - Reads are combinational into A and B, which latch every cycle.
- FSM states and transitions:
  - FETCH: req, adr=PC, we=0. On ready: IR<=rdata, PC<=PC+4, go to DECODE. Otherwise stay.
  - DECODE: ALUOut<=PC+(sext(imm)<<2). Dispatch on opcode:
    - 0x00 -> REXEC; 0x23/0x2B -> MADR; 0x04 -> BEQ; 0x02 -> JMP; 0x03 -> JAL; 0x08 -> IEXEC; else -> HALT.
  - REXEC: ALUOut<=A op B, by funct:
    - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0).
    - Other funct -> HALT. Valid funct -> RWB.
  - RWB: rd<=ALUOut; go to FETCH.
  - IEXEC: ALUOut<=A+sext(imm); go to IWB. IWB: rt<=ALUOut; go to FETCH.
  - MADR: ALUOut<=A+sext(imm); lw -> MRD, sw -> MWR.
  - MRD: req, adr=ALUOut, we=0; on ready MDR<=rdata, go to LWB. LWB: rt<=MDR; go to FETCH.
  - MWR: req, we=1, adr=ALUOut, wdata=B; on ready go to FETCH.
  - BEQ: if A==B then PC<=ALUOut; go to FETCH.
  - JMP: PC<={PC[31:28],IR[25:0],2'b00}; go to FETCH.
  - JAL: $31<=PC (already +4), same PC update as JMP; go to FETCH.
  - HALT: halt=1, no requests, no state change until reset.
- Arithmetic:
  - All 32-bit with modulo wrap-around; no overflow trap.
  - PC+4 wraps at 2^32.
  - Addresses are not alignment-checked; the low 2 bits are passed through.
- Latency with zero-wait memory, fetch to next FETCH:
  - R-type 4, addi 4, lw 5, sw 4, beq 3, j 3, jal 3.
  - Each memory wait cycle adds 1.

Optional Feature:
- Macro: MC_MIPS_BNE_EN.
- Defined: opcode 0x05 dispatches to a BNE state; PC<=ALUOut if A!=B; 3 cycles.
- Undefined: opcode 0x05 is illegal and goes to HALT.

Test Plan:
- Reset: rst=0 mid-FETCH with mem_req=1 -> mem_req drops that cycle; after release the first mem_adr=RESET_PC; halt=0.
- ALU/ADDI, zero-wait: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sub $4,$1,$2; slt $5,$1,$2 -> $3=12, $4=32'hFFFF_FFFE, $5=1; add completes in 4 cycles.
- Memory wait states, mem_ready delayed 3 cycles per access: sw $3,8($0) then lw $6,8($0) -> write of 12 at address 8; $6=12; address/data stable throughout each wait; lw takes 5+6=11 cycles.
- Control flow: beq $1,$1,+2 -> PC=fetch+4+8; j 0x0000040 -> PC=0x100; jal from PC 0x200 -> $31=0x204.
- $0 protection: addi $0,$0,9 then add $7,$0,$0 -> $7=0.
- Illegal instruction: opcode 0x3F, or funct 0x3F -> halt=1, mem_req stays 0 indefinitely; with MC_MIPS_BNE_EN, bne $1,$2,+1 with $1!=$2 is taken and halt=0.
